// File: rtl/register_file_if.sv
// register_file_if: write port (we/waddr/wdata) and two read ports (re/raddr in, rdata/valid out) of the register bank
interface register_file_if #(
  parameter int width = 8,
  parameter int awidth = 3
);
  logic we;
  logic [awidth-1:0] waddr;
  logic [width-1:0] wdata;
  logic re_a;
  logic [awidth-1:0] raddr_a;
  logic re_b;
  logic [awidth-1:0] raddr_b;
  logic [width-1:0] rdata_a;
  logic [width-1:0] rdata_b;
  logic valid_a;
  logic valid_b;
  modport master (
    output we, waddr, wdata, re_a, raddr_a, re_b, raddr_b,
    input rdata_a, rdata_b, valid_a, valid_b
  );
  modport slave (
    input we, waddr, wdata, re_a, raddr_a, re_b, raddr_b,
    output rdata_a, rdata_b, valid_a, valid_b
  );
endinterface

// File: rtl/register_file.sv
// register_file: 1W/2R register bank, entry 0 reads zero, registered reads with write bypass; ports clk, rst (async active-low), bus (slave)
module register_file #(
  parameter int width = 8,
  parameter int depth = 8,
  parameter int awidth = 3
) (
  input logic clk,
  input logic rst,
  register_file_if.slave bus
);
  logic [depth-1:0][width-1:0] mem;
  logic [width-1:0] next_a, next_b, rdata_a, rdata_b;
  logic valid_a, valid_b;
  always_comb begin
    next_a = bus.raddr_a == '0 ? '0 : bus.we && bus.waddr == bus.raddr_a ? bus.wdata : mem[bus.raddr_a];
    next_b = bus.raddr_b == '0 ? '0 : bus.we && bus.waddr == bus.raddr_b ? bus.wdata : mem[bus.raddr_b];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) mem <= '0;
    else if (bus.we && bus.waddr != '0) mem[bus.waddr] <= bus.wdata;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rdata_a <= '0;
      rdata_b <= '0;
      valid_a <= 1'b0;
      valid_b <= 1'b0;
    end else begin
      valid_a <= bus.re_a;
      valid_b <= bus.re_b;
      if (bus.re_a) rdata_a <= next_a;
      if (bus.re_b) rdata_b <= next_b;
    end
  assign bus.rdata_a = rdata_a;
  assign bus.rdata_b = rdata_b;
  assign bus.valid_a = valid_a;
  assign bus.valid_b = valid_b;
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed and random checks of register_file against an array model
module tb_register_file;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int compared = 0;
  int mismatched = 0;
  logic [7:0] model [8];
  logic [7:0] exp_ra, exp_rb;
  logic exp_va, exp_vb;
  register_file_if #(.width(8), .awidth(3)) bus ();
  register_file #(.width(8), .depth(8), .awidth(3)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] expect_read(input logic [2:0] a);
    if (a == 3'd0) return 8'h00;
    if (bus.we && bus.waddr == a) return bus.wdata;
    return model[a];
  endfunction
  task automatic idle();
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.re_a = 1'b0; bus.raddr_a = '0; bus.re_b = 1'b0; bus.raddr_b = '0;
  endtask
  task automatic cycle();
    if (bus.re_a) exp_ra = expect_read(bus.raddr_a);
    if (bus.re_b) exp_rb = expect_read(bus.raddr_b);
    exp_va = bus.re_a;
    exp_vb = bus.re_b;
    if (bus.we && bus.waddr != 3'd0) model[bus.waddr] = bus.wdata;
    @(posedge clk);
    #1;
    check("rdata_a", bus.rdata_a, exp_ra);
    check("rdata_b", bus.rdata_b, exp_rb);
    check("valid_a", {7'd0, bus.valid_a}, {7'd0, exp_va});
    check("valid_b", {7'd0, bus.valid_b}, {7'd0, exp_vb});
  endtask
  task automatic model_reset();
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    exp_ra = 8'h00; exp_rb = 8'h00; exp_va = 1'b0; exp_vb = 1'b0;
  endtask
  initial begin
    idle();
    model_reset();
    #12;
    check("reset_rdata_a", bus.rdata_a, 8'h00);
    check("reset_rdata_b", bus.rdata_b, 8'h00);
    check("reset_valid", {6'd0, bus.valid_a, bus.valid_b}, 8'h00);
    rst = 1'b1;
    @(posedge clk); #1;
    bus.we = 1'b1; bus.waddr = 3'd3; bus.wdata = 8'hAA;
    cycle();
    idle(); bus.re_a = 1'b1; bus.raddr_a = 3'd3;
    cycle();
    check("pre_reset_read", bus.rdata_a, 8'hAA);
    idle();
    #3 rst = 1'b0;
    #1;
    model_reset();
    check("async_rdata_a", bus.rdata_a, 8'h00);
    check("async_valid_a", {7'd0, bus.valid_a}, 8'h00);
    #1 rst = 1'b1;
    bus.re_a = 1'b1; bus.raddr_a = 3'd3;
    cycle();
    check("post_reset_read", bus.rdata_a, 8'h00);
    idle(); bus.we = 1'b1; bus.waddr = 3'd5; bus.wdata = 8'h3C;
    cycle();
    idle(); bus.re_a = 1'b1; bus.raddr_a = 3'd5;
    cycle();
    check("wr_rd_data", bus.rdata_a, 8'h3C);
    check("wr_rd_valid", {7'd0, bus.valid_a}, 8'h01);
    idle();
    cycle();
    check("hold_data", bus.rdata_a, 8'h3C);
    check("hold_valid", {7'd0, bus.valid_a}, 8'h00);
    bus.we = 1'b0; bus.waddr = 3'd2; bus.wdata = 8'hFF;
    cycle();
    idle(); bus.re_a = 1'b1; bus.raddr_a = 3'd2;
    cycle();
    check("we0_guard", bus.rdata_a, 8'h00);
    idle(); bus.we = 1'b1; bus.waddr = 3'd0; bus.wdata = 8'h55;
    bus.re_a = 1'b1; bus.re_b = 1'b1;
    cycle();
    check("zero_bypass_a", bus.rdata_a, 8'h00);
    check("zero_bypass_b", bus.rdata_b, 8'h00);
    idle(); bus.re_a = 1'b1; bus.re_b = 1'b1;
    cycle();
    check("zero_read_a", bus.rdata_a, 8'h00);
    check("zero_read_b", bus.rdata_b, 8'h00);
    idle(); bus.we = 1'b1; bus.waddr = 3'd4; bus.wdata = 8'h11;
    cycle();
    bus.wdata = 8'h22; bus.re_a = 1'b1; bus.raddr_a = 3'd4; bus.re_b = 1'b1; bus.raddr_b = 3'd4;
    cycle();
    check("bypass_a", bus.rdata_a, 8'h22);
    check("bypass_b", bus.rdata_b, 8'h22);
    for (int i = 1; i < 8; i++) begin
      idle(); bus.we = 1'b1; bus.waddr = 3'(i); bus.wdata = 8'(i * 16);
      cycle();
    end
    for (int i = 1; i < 8; i++) begin
      idle(); bus.re_a = 1'b1; bus.raddr_a = 3'(i); bus.re_b = 1'b1; bus.raddr_b = 3'(8 - i);
      cycle();
      check("loop_a", bus.rdata_a, 8'(i * 16));
      check("loop_b", bus.rdata_b, 8'((8 - i) * 16));
      check("loop_valid", {6'd0, bus.valid_a, bus.valid_b}, 8'h03);
    end
    for (int n = 0; n < 400; n++) begin
      bus.we = 1'($urandom_range(0, 1));
      bus.waddr = 3'($urandom_range(0, 7));
      bus.wdata = 8'($urandom);
      bus.re_a = 1'($urandom_range(0, 1));
      bus.raddr_a = 3'($urandom_range(0, 7));
      bus.re_b = 1'($urandom_range(0, 1));
      bus.raddr_b = ($urandom_range(0, 3) == 0) ? bus.waddr : 3'($urandom_range(0, 7));
      cycle();
    end
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Multi-entry register bank for the FRANK6000 datapath. It is the read-side counterpart to the single `Register` storage element.
- One write port and two independent read ports. Read data is registered, with 1-cycle latency.
- Write-to-read bypass means an operand read sees a same-cycle write.
- Sits between instruction decode (register addresses) and the ALU operand inputs.

Parameters:
- width, 8, bits per register entry
- depth, 8, number of entries; must be a power of two, minimum 2
- awidth, 3, address width; must equal log2(depth)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low (rst=0 resets immediately, independent of clk)
- we  input  1  write enable for the write port
- waddr  input  awidth  write address
- wdata  input  width  write data
- re_a  input  1  read enable, port A
- raddr_a  input  awidth  read address, port A
- re_b  input  1  read enable, port B
- raddr_b  input  awidth  read address, port B
- rdata_a  output  width  registered read data, port A
- rdata_b  output  width  registered read data, port B
- valid_a  output  1  high for exactly one cycle when rdata_a is updated by a read
- valid_b  output  1  high for exactly one cycle when rdata_b is updated by a read

Behaviour:
- Reset (rst=0, asynchronous):
  - All entries become 0.
  - rdata_a, rdata_b, valid_a and valid_b become 0.
  - While rst=0, writes and reads are ignored.
  - Reset arriving mid-read discards the pending output; no valid pulse follows.
- Entry 0 is hardwired to zero:
  - Writes to waddr=0 are discarded.
  - Reads of address 0 always return 0, including under bypass.
- Write:
  - On a rising edge with rst=1, we=1 and waddr!=0, mem[waddr] <= wdata.
  - we=0 leaves every entry unchanged.
- Read, port A (port B identical, independent):
  - On a rising edge with re_a=1, rdata_a <= value of entry raddr_a and valid_a <= 1.
  - With re_a=0, rdata_a holds its previous value and valid_a <= 0.
  - Latency: address presented before edge N, data visible after edge N.
- Bypass:
  - If re_a=1, we=1, raddr_a==waddr and waddr!=0 on the same edge, rdata_a <= wdata (the new value, not the stale entry).
  - The same rule applies to port B.
- Simultaneous events:
  - Both ports may read the same address on the same edge; both return identical data.
  - Both ports may read while a write targets either or both addresses; bypass applies per port.
  - Write and read at different addresses on the same edge do not interact.
- Address range is full (depth = 2^awidth), so no out-of-range handling is required.
- No combinational path from any input to any output except through rst.

Test Plan:
- Reset: write 8'hAA to entry 3, pulse rst=0 for 2 ns between edges, then read entry 3 on A -> rdata_a=8'h00 immediately after the pulse, and 8'h00 after the read edge; valid_a=0 during reset.
- Write then read: we=1, waddr=5, wdata=8'h3C for one edge; next edge re_a=1, raddr_a=5 -> after that edge rdata_a=8'h3C, valid_a=1 for one cycle, then 0 with rdata_a held.
- we=0 guard: we=0, waddr=2, wdata=8'hFF; read entry 2 -> rdata_a=8'h00.
- Entry 0: we=1, waddr=0, wdata=8'h55; read address 0 on both ports, including a same-edge bypass read -> rdata_a=rdata_b=8'h00.
- Bypass: entry 4 holds 8'h11; on one edge we=1, waddr=4, wdata=8'h22, re_a=1, raddr_a=4, re_b=1, raddr_b=4 -> rdata_a=rdata_b=8'h22 after that edge.
- Loop: for i=1..7 write entry i with value i*8'h10; then read port A address i and port B address 8-i each cycle (i=1..7) -> rdata_a=i*8'h10 and rdata_b=(8-i)*8'h10 each cycle, valid_a and valid_b high for all 7 cycles.
